// File: rtl/mag_tape_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mag_tape_seq                                                    |
// | Purpose  : Multi-drive magnetic tape motion sequencer. Decodes the DS/S/   |
// |            SU/SV/SW command lines, latches direction and unit, and walks   |
// |            the selected drive through ACCEL, RUN and DECEL phases with     |
// |            end/beginning-of-tape protection, a timed file-mark pulse and   |
// |            ready/busy/error status.                                        |
// | Options  : MAG_TAPE_REWIND_EN - adds the SU&S3 rewind command and the      |
// |            REWIND state (reverse motion until BOT, independent of DS).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mag_tape_seq #(
  parameter int NUM_DRIVES = 4,   // 1..8
  parameter int START_DLY  = 16,  // 1..65535
  parameter int STOP_DLY   = 12,  // 1..65535
  parameter int MARK_LEN   = 4,   // 1..255
  localparam int UW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                  CLOCK,
  input  logic                  rst,
  input  logic                  DS,
  input  logic                  S0,
  input  logic                  S1,
  input  logic                  S3,
  input  logic                  S7,
  input  logic                  SU,
  input  logic                  SV,
  input  logic                  SW,
  input  logic [UW-1:0]         UNIT_SEL,
  input  logic [NUM_DRIVES-1:0] TAPE_BOT,
  input  logic [NUM_DRIVES-1:0] TAPE_EOT,
  output logic [NUM_DRIVES-1:0] MAG_TAPE_FWD,
  output logic [NUM_DRIVES-1:0] MAG_TAPE_REV,
  output logic                  MAG6_OUT,
  output logic                  TAPE_READY,
  output logic                  TAPE_BUSY,
  output logic                  TAPE_AT_SPEED,
  output logic                  TAPE_ERR
);

  localparam int            CW         = 16;
  localparam logic [CW-1:0] START_LOAD = CW'(START_DLY - 1);
  localparam logic [CW-1:0] STOP_LOAD  = CW'(STOP_DLY - 1);
  localparam logic [CW-1:0] MARK_LOAD  = CW'(MARK_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DECEL  = 3'd3,
`ifdef MAG_TAPE_REWIND_EN
    ST_MARK   = 3'd4,
    ST_REWIND = 3'd5
`else
    ST_MARK   = 3'd4
`endif
  } state_t;

  // Registered state and outputs
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ds_prev_q, ds_prev_d;
  logic                    dir_fwd_q, dir_fwd_d;
  logic [NUM_DRIVES-1:0]   unit_oh_q, unit_oh_d;
  logic [NUM_DRIVES-1:0]   fwd_q, fwd_d;
  logic [NUM_DRIVES-1:0]   rev_q, rev_d;
  logic                    mark_q, mark_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    at_speed_q, at_speed_d;
  logic                    err_q, err_d;

  // Command decode and sensor selection
  logic                    fwd_cmd, rev_cmd, mark_cmd, rewind_cmd;
  logic                    ds_rise;
  logic [NUM_DRIVES-1:0]   sel_oh;
  logic                    sel_valid;
  logic                    acc_eot, acc_bot;
  logic                    cur_eot, cur_bot;
  logic                    limit_hit;
  logic                    is_rewind;
  logic                    motion_d;

  assign fwd_cmd  = (DS & SV & S1) | (DS & SV & S3) | (DS & SW & S0);
  assign rev_cmd  = DS & SU & S1;
  assign mark_cmd = DS & SW & S7;
  assign ds_rise  = DS & ~ds_prev_q;

`ifdef MAG_TAPE_REWIND_EN
  logic rewind_q, rewind_d;
  assign rewind_cmd = DS & SU & S3;
  assign is_rewind  = rewind_q;
`else
  assign rewind_cmd = 1'b0;
  assign is_rewind  = 1'b0;
`endif

  // One-hot decode of UNIT_SEL; codes beyond the last drive decode to zero.
  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_sel_oh
    assign sel_oh[i] = (UNIT_SEL == UW'(i));
  end

  assign sel_valid = |sel_oh;
  assign acc_eot   = |(TAPE_EOT & sel_oh);
  assign acc_bot   = |(TAPE_BOT & sel_oh);
  assign cur_eot   = |(TAPE_EOT & unit_oh_q);
  assign cur_bot   = |(TAPE_BOT & unit_oh_q);
  assign limit_hit = dir_fwd_q ? cur_eot : cur_bot;

  // Next-state, counter, latch and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ds_prev_d = DS;
    dir_fwd_d = dir_fwd_q;
    unit_oh_d = unit_oh_q;
    err_d     = err_q;
`ifdef MAG_TAPE_REWIND_EN
    rewind_d  = rewind_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Out-of-range units are dropped without touching state or error.
        if (ds_rise && sel_valid) begin
          if (fwd_cmd || rev_cmd || rewind_cmd) begin
            if (fwd_cmd ? acc_eot : acc_bot) begin
              // Already at the limit for the requested direction.
              err_d = 1'b1;
            end else begin
              err_d     = 1'b0;
              dir_fwd_d = fwd_cmd;
              unit_oh_d = sel_oh;
              state_d   = ST_ACCEL;
              cnt_d     = START_LOAD;
`ifdef MAG_TAPE_REWIND_EN
              rewind_d  = !fwd_cmd && !rev_cmd;
`endif
            end
          end else if (mark_cmd) begin
            err_d   = 1'b0;
            state_d = ST_MARK;
            cnt_d   = MARK_LOAD;
          end
        end
      end

      ST_ACCEL: begin
        if (limit_hit) begin
          // A rewind reaching BOT is the expected end, not a fault.
          if (!is_rewind) err_d = 1'b1;
          state_d = ST_DECEL;
          cnt_d   = STOP_LOAD;
        end else if (!DS && !is_rewind) begin
          state_d = ST_DECEL;
          cnt_d   = STOP_LOAD;
        end else if (cnt_q == '0) begin
`ifdef MAG_TAPE_REWIND_EN
          state_d = is_rewind ? ST_REWIND : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_RUN: begin
        if (limit_hit) begin
          err_d   = 1'b1;
          state_d = ST_DECEL;
          cnt_d   = STOP_LOAD;
        end else if (!DS) begin
          state_d = ST_DECEL;
          cnt_d   = STOP_LOAD;
        end
      end

      ST_DECEL, ST_MARK: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

`ifdef MAG_TAPE_REWIND_EN
      ST_REWIND: begin
        if (cur_bot) begin
          state_d = ST_DECEL;
          cnt_d   = STOP_LOAD;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they change on the same
    // edge as the state register.
    motion_d = (state_d == ST_ACCEL) || (state_d == ST_RUN);
`ifdef MAG_TAPE_REWIND_EN
    motion_d = motion_d || (state_d == ST_REWIND);
`endif
    fwd_d      = (motion_d &&  dir_fwd_d) ? unit_oh_d : '0;
    rev_d      = (motion_d && !dir_fwd_d) ? unit_oh_d : '0;
    mark_d     = (state_d == ST_MARK);
    ready_d    = (state_d == ST_IDLE);
    busy_d     = motion_d || (state_d == ST_DECEL);
    at_speed_d = (state_d == ST_RUN);
  end

  // Single state/output register bank with asynchronous reset to IDLE
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ds_prev_q  <= 1'b0;
      dir_fwd_q  <= 1'b0;
      unit_oh_q  <= '0;
      fwd_q      <= '0;
      rev_q      <= '0;
      mark_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef MAG_TAPE_REWIND_EN
      rewind_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ds_prev_q  <= ds_prev_d;
      dir_fwd_q  <= dir_fwd_d;
      unit_oh_q  <= unit_oh_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      mark_q     <= mark_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      at_speed_q <= at_speed_d;
      err_q      <= err_d;
`ifdef MAG_TAPE_REWIND_EN
      rewind_q   <= rewind_d;
`endif
    end
  end

  assign MAG_TAPE_FWD  = fwd_q;
  assign MAG_TAPE_REV  = rev_q;
  assign MAG6_OUT      = mark_q;
  assign TAPE_READY    = ready_q;
  assign TAPE_BUSY     = busy_q;
  assign TAPE_AT_SPEED = at_speed_q;
  assign TAPE_ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_tape_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mag_tape_seq                                                 |
// | Purpose  : Directed self-checking bench for mag_tape_seq (default build).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mag_tape_seq;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       DS, S0, S1, S3, S7, SU, SV, SW;
  logic [1:0] UNIT_SEL;
  logic [3:0] TAPE_BOT, TAPE_EOT;
  logic [3:0] MAG_TAPE_FWD, MAG_TAPE_REV;
  logic       MAG6_OUT, TAPE_READY, TAPE_BUSY, TAPE_AT_SPEED, TAPE_ERR;

  // Second instance with three drives so an unrepresentable-free,
  // out-of-range UNIT_SEL code (3) exists.
  logic       ds3;
  logic [1:0] unit_sel3;
  logic [2:0] bot3, eot3;
  logic [2:0] fwd3, rev3;
  logic       mag3, ready3, busy3, at3, err3;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] st, exp;
  logic [8:0]  st3, exp3;

  always #5 CLOCK = ~CLOCK;

  mag_tape_seq #(.NUM_DRIVES(4), .START_DLY(16), .STOP_DLY(12), .MARK_LEN(4)) dut (
    .CLOCK(CLOCK), .rst(rst), .DS(DS), .S0(S0), .S1(S1), .S3(S3), .S7(S7),
    .SU(SU), .SV(SV), .SW(SW), .UNIT_SEL(UNIT_SEL), .TAPE_BOT(TAPE_BOT),
    .TAPE_EOT(TAPE_EOT), .MAG_TAPE_FWD(MAG_TAPE_FWD), .MAG_TAPE_REV(MAG_TAPE_REV),
    .MAG6_OUT(MAG6_OUT), .TAPE_READY(TAPE_READY), .TAPE_BUSY(TAPE_BUSY),
    .TAPE_AT_SPEED(TAPE_AT_SPEED), .TAPE_ERR(TAPE_ERR)
  );

  mag_tape_seq #(.NUM_DRIVES(3), .START_DLY(4), .STOP_DLY(3), .MARK_LEN(2)) dut3 (
    .CLOCK(CLOCK), .rst(rst), .DS(ds3), .S0(S0), .S1(S1), .S3(S3), .S7(S7),
    .SU(SU), .SV(SV), .SW(SW), .UNIT_SEL(unit_sel3), .TAPE_BOT(bot3),
    .TAPE_EOT(eot3), .MAG_TAPE_FWD(fwd3), .MAG_TAPE_REV(rev3),
    .MAG6_OUT(mag3), .TAPE_READY(ready3), .TAPE_BUSY(busy3),
    .TAPE_AT_SPEED(at3), .TAPE_ERR(err3)
  );

  assign st  = {MAG_TAPE_FWD, MAG_TAPE_REV, MAG6_OUT, TAPE_READY, TAPE_BUSY, TAPE_AT_SPEED, TAPE_ERR};
  assign st3 = {fwd3, rev3, mag3, ready3, busy3, at3, err3};

  // Packs an expected status word {FWD, REV, MAG6, READY, BUSY, AT_SPEED, ERR}.
  function automatic logic [12:0] mk(input logic [3:0] f, input logic [3:0] r,
                                     input logic m, input logic rd, input logic b,
                                     input logic a, input logic e);
    return {f, r, m, rd, b, a, e};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic clear_cmd();
    DS = 0; S0 = 0; S1 = 0; S3 = 0; S7 = 0; SU = 0; SV = 0; SW = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_cmd(); UNIT_SEL = 0; TAPE_BOT = 0; TAPE_EOT = 0;
    ds3 = 0; unit_sel3 = 0; bot3 = 0; eot3 = 0;
    tick(2);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL reset_state: got %b want %b", st, exp); end
    exp3 = {3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (st3 !== exp3) begin n_bad++; $display("FAIL reset_state_3: got %b want %b", st3, exp3); end
    rst = 0;
    tick(2);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL post_reset_idle: got %b want %b", st, exp); end
  endtask

  // Forward on unit 2 with limit sensors active on every other unit
  // (and BOT on unit 2, irrelevant for forward motion).
  task automatic test_fwd();
    UNIT_SEL = 2; TAPE_EOT = 4'b1011; TAPE_BOT = 4'b0100;
    DS = 1; SV = 1; S1 = 1;
    tick(1);
    exp = mk(4'b0100, 4'b0, 0, 0, 1, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_accel_start: got %b want %b", st, exp); end
    tick(15);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_accel_last: got %b want %b", st, exp); end
    tick(1);
    exp = mk(4'b0100, 4'b0, 0, 0, 1, 1, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_at_speed: got %b want %b", st, exp); end
    tick(3);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_run_hold: got %b want %b", st, exp); end
    DS = 0; SV = 0; S1 = 0;
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 0, 1, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_decel_entry: got %b want %b", st, exp); end
    tick(11);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_decel_last: got %b want %b", st, exp); end
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_ready_again: got %b want %b", st, exp); end
    TAPE_EOT = 0; TAPE_BOT = 0;
  endtask

  // Reverse on unit 1, BOT hit in RUN, then DS held through DECEL->IDLE.
  task automatic test_rev_bot();
    UNIT_SEL = 1; DS = 1; SU = 1; S1 = 1;
    tick(1);
    exp = mk(4'b0, 4'b0010, 0, 0, 1, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL rev_accel: got %b want %b", st, exp); end
    tick(16);
    exp = mk(4'b0, 4'b0010, 0, 0, 1, 1, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL rev_at_speed: got %b want %b", st, exp); end
    TAPE_BOT = 4'b0010;
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 0, 1, 0, 1);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL rev_bot_stop: got %b want %b", st, exp); end
    tick(11);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL rev_bot_decel_last: got %b want %b", st, exp); end
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 1);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL rev_bot_idle_err: got %b want %b", st, exp); end
    TAPE_BOT = 0;
    tick(3);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL ds_held_no_restart: got %b want %b", st, exp); end
    clear_cmd();
    tick(1);
  endtask

  // File mark; acceptance also clears the error left by the previous test.
  task automatic test_mark();
    DS = 1; SW = 1; S7 = 1;
    exp = mk(4'b0, 4'b0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL mark_pulse_%0d: got %b want %b", i, st, exp); end
    end
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL mark_done: got %b want %b", st, exp); end
    clear_cmd();
    tick(1);
  endtask

  task automatic test_limit_at_accept();
    TAPE_EOT = 4'b0001; UNIT_SEL = 0; DS = 1; SV = 1; S3 = 1;
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 1);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL eot_at_accept: got %b want %b", st, exp); end
    tick(2);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL eot_at_accept_hold: got %b want %b", st, exp); end
    clear_cmd(); TAPE_EOT = 0;
    tick(1);
  endtask

  // Forward and reverse decoded together; DS dropped during ACCEL.
  task automatic test_both_cmds();
    UNIT_SEL = 3; DS = 1; SV = 1; S1 = 1; SU = 1;
    tick(1);
    exp = mk(4'b1000, 4'b0, 0, 0, 1, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_wins: got %b want %b", st, exp); end
    clear_cmd();
    tick(1);
    exp = mk(4'b0, 4'b0, 0, 0, 1, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL accel_ds_drop: got %b want %b", st, exp); end
    tick(12);
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL fwd_wins_idle: got %b want %b", st, exp); end
  endtask

  task automatic test_unit_range();
    SV = 1; S1 = 1; unit_sel3 = 2'd3; ds3 = 1;
    tick(1);
    exp3 = {3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (st3 !== exp3) begin n_bad++; $display("FAIL unit_out_of_range: got %b want %b", st3, exp3); end
    tick(3);
    n_cmp++; if (st3 !== exp3) begin n_bad++; $display("FAIL unit_out_of_range_hold: got %b want %b", st3, exp3); end
    ds3 = 0;
    tick(1);
    unit_sel3 = 2'd2; ds3 = 1;
    tick(1);
    exp3 = {3'b100, 3'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (st3 !== exp3) begin n_bad++; $display("FAIL unit_in_range: got %b want %b", st3, exp3); end
    ds3 = 0; clear_cmd();
    tick(4);
    exp3 = {3'b0, 3'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++; if (st3 !== exp3) begin n_bad++; $display("FAIL unit_in_range_idle: got %b want %b", st3, exp3); end
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL main_untouched: got %b want %b", st, exp); end
  endtask

  task automatic test_async_reset();
    UNIT_SEL = 1; DS = 1; SV = 1; S1 = 1;
    tick(18);
    exp = mk(4'b0010, 4'b0, 0, 0, 1, 1, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL pre_reset_run: got %b want %b", st, exp); end
    #1 rst = 1; clear_cmd();
    #1;
    exp = mk(4'b0, 4'b0, 0, 1, 0, 0, 0);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL async_reset_immediate: got %b want %b", st, exp); end
    #1 rst = 0;
    tick(2);
    n_cmp++; if (st !== exp) begin n_bad++; $display("FAIL after_async_reset: got %b want %b", st, exp); end
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_rev_bot();
    test_mark();
    test_limit_at_accept();
    test_both_cmds();
    test_unit_range();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
